// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC and issues in-order word requests
// to instruction memory. Responses are buffered in a small queue, and the oldest
// word is presented to IDU0 together with its PC. Redirects discard all queued
// and in-flight work. Responses that are still outstanding across a redirect are
// counted out through discard_cnt.

// Protocol checker for the fetch unit. Simulation only; synthesis ignores it.
module ifu_fetch_chk #(
  parameter int XLEN  = 32,
  parameter int CW    = 2,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  input  logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic            pipe_flush,
  input  logic [CW-1:0]   alloc_cnt,
  input  logic [CW-1:0]   discard_cnt,
  input  logic [CW-1:0]   unfilled_cnt
);

  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  // Every response must either be discarded or fill an outstanding entry.
  rsp_has_owner: assert property (@(posedge clk) disable iff (!rstn)
    rsp_valid |-> ((discard_cnt != {CW{1'b0}}) || (unfilled_cnt != {CW{1'b0}})));

  // Queued entries plus responses still to be discarded never exceed the queue depth.
  credit_bound: assert property (@(posedge clk) disable iff (!rstn)
    (({1'b0, alloc_cnt} + {1'b0, discard_cnt}) <= DEPTH_W));

  // A stalled request stays valid at the same address unless a redirect cancels it.
  req_held: assert property (@(posedge clk) disable iff (!rstn)
    (req_valid && !req_ready) |=>
      (pipe_flush || (req_valid && (req_addr == $past(req_addr)))));

endmodule

module ifu_fetch #(
  parameter int              XLEN      = 32,
  parameter int              INSTR_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 fetch_en,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [XLEN-1:0]      imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [INSTR_LEN-1:0] imem_rsp_data,
  input  logic                 pipe_stall,
  input  logic                 pipe_flush,
  input  logic [XLEN-1:0]      flush_pc,
  output logic [INSTR_LEN-1:0] instr,
  output logic                 instr_valid,
  output logic [XLEN-1:0]      instr_tag
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW:0]     DEPTH_W    = (CW+1)'(DEPTH);
  localparam logic [PW-1:0]   PTR_ONE    = PW'(1);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t state;

  // Fetch PC. It is always the address of the next request to issue.
  logic [XLEN-1:0] pc;

  // Queue storage. Entries are allocated at tail_ptr, filled in order at
  // fill_ptr, and retired at head_ptr.
  logic [XLEN-1:0]      q_pc   [DEPTH];
  logic [INSTR_LEN-1:0] q_data [DEPTH];
  logic [DEPTH-1:0]     q_filled;

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [PW-1:0] fill_ptr;

  logic [CW-1:0] alloc_cnt;     // entries allocated (filled or not)
  logic [CW-1:0] unfilled_cnt;  // allocated entries still awaiting their response
  logic [CW-1:0] discard_cnt;   // responses still owed to requests cancelled by a redirect

  logic [CW:0] credit_used;
  logic        req_ok;
  logic        req_fire;
  logic        rsp_drop;
  logic        rsp_fill;
  logic        head_alloc;
  logic        head_bypass;
  logic        pop;

  // A request slot stays reserved until its response has been consumed or discarded.
  assign credit_used = {1'b0, alloc_cnt} + {1'b0, discard_cnt};
  assign req_ok      = (credit_used < DEPTH_W);

  assign imem_req_valid = (state == ST_FETCH) && req_ok && !pipe_flush;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses pay off discards first, then fill entries in request order.
  assign rsp_drop = imem_rsp_valid && (discard_cnt != {CW{1'b0}});
  assign rsp_fill = imem_rsp_valid && (discard_cnt == {CW{1'b0}});

  // The head can be handed over in the same cycle its response arrives.
  assign head_alloc  = (alloc_cnt != {CW{1'b0}});
  assign head_bypass = rsp_fill && head_alloc && (fill_ptr == head_ptr) && !q_filled[head_ptr];
  assign instr_valid = head_alloc && (q_filled[head_ptr] || head_bypass);

  assign pop = instr_valid && !pipe_stall && !pipe_flush;

  // Drive the head word and its PC to IDU0, or zeros when nothing is presentable.
  always_comb begin
    instr     = {INSTR_LEN{1'b0}};
    instr_tag = {XLEN{1'b0}};
    if (instr_valid) begin
      instr_tag = q_pc[head_ptr];
      if (q_filled[head_ptr]) begin
        instr = q_data[head_ptr];
      end else begin
        instr = imem_rsp_data;
      end
    end else begin
      instr     = {INSTR_LEN{1'b0}};
      instr_tag = {XLEN{1'b0}};
    end
  end

  // Control FSM. Leave FETCH only when no request is stalled at the memory port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_BOOT;
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (!fetch_en && !(imem_req_valid && !imem_req_ready)) begin
            state <= ST_HALT;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_HALT: begin
          if (fetch_en) begin
            state <= ST_FETCH;
          end else begin
            state <= ST_HALT;
          end
        end
        default: begin
          state <= ST_BOOT;
        end
      endcase
    end
  end

  // PC, queue and counters. A redirect empties the queue. Any response still
  // owed, minus one that arrives during the redirect cycle, becomes a discard.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc           <= RESET_PC;
      head_ptr     <= {PW{1'b0}};
      tail_ptr     <= {PW{1'b0}};
      fill_ptr     <= {PW{1'b0}};
      alloc_cnt    <= {CW{1'b0}};
      unfilled_cnt <= {CW{1'b0}};
      discard_cnt  <= {CW{1'b0}};
      q_filled     <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= {XLEN{1'b0}};
        q_data[i] <= {INSTR_LEN{1'b0}};
      end
    end else if (pipe_flush) begin
      pc           <= flush_pc & ALIGN_MASK;
      head_ptr     <= {PW{1'b0}};
      tail_ptr     <= {PW{1'b0}};
      fill_ptr     <= {PW{1'b0}};
      alloc_cnt    <= {CW{1'b0}};
      unfilled_cnt <= {CW{1'b0}};
      discard_cnt  <= discard_cnt + unfilled_cnt - CW'(imem_rsp_valid);
      q_filled     <= {DEPTH{1'b0}};
    end else begin
      if (req_fire) begin
        q_pc[tail_ptr]     <= pc;
        q_filled[tail_ptr] <= 1'b0;
        tail_ptr           <= tail_ptr + PTR_ONE;
        pc                 <= pc + PC_STEP;
      end
      if (rsp_fill) begin
        q_data[fill_ptr]   <= imem_rsp_data;
        q_filled[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + PTR_ONE;
      end
      if (rsp_drop) begin
        discard_cnt <= discard_cnt - CNT_ONE;
      end
      if (pop) begin
        head_ptr <= head_ptr + PTR_ONE;
      end
      alloc_cnt    <= alloc_cnt + CW'(req_fire) - CW'(pop);
      unfilled_cnt <= unfilled_cnt + CW'(req_fire) - CW'(rsp_fill);
    end
  end

  ifu_fetch_chk #(
    .XLEN  (XLEN),
    .CW    (CW),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (imem_req_valid),
    .req_ready    (imem_req_ready),
    .req_addr     (imem_req_addr),
    .rsp_valid    (imem_rsp_valid),
    .pipe_flush   (pipe_flush),
    .alloc_cnt    (alloc_cnt),
    .discard_cnt  (discard_cnt),
    .unfilled_cnt (unfilled_cnt)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed testbench for ifu_fetch (DEPTH=2, RESET_PC=0).
// The memory model returns addr+0x1000_0000 one cycle after the request is accepted.
// Setting hold parks responses until hold is cleared.
// Inputs are driven and outputs are checked at the falling edge.
module tb_ifu_fetch;

  logic        clk;
  logic        rstn;
  logic        fetch_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        pipe_stall;
  logic        pipe_flush;
  logic [31:0] flush_pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] instr_tag;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic        hold;
  logic [31:0] pend[$];

  ifu_fetch #(
    .XLEN      (32),
    .INSTR_LEN (32),
    .RESET_PC  (32'h0000_0000),
    .DEPTH     (2)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .fetch_en       (fetch_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pipe_stall     (pipe_stall),
    .pipe_flush     (pipe_flush),
    .flush_pc       (flush_pc),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_tag      (instr_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance from one falling edge to the next, playing the memory side.
  task automatic step();
    logic        fire;
    logic [31:0] a;
    fire = imem_req_valid && imem_req_ready;
    a    = imem_req_addr;
    @(posedge clk);
    #1;
    if (fire) pend.push_back(a);
    if (!hold && (pend.size() > 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend.pop_front() + 32'h1000_0000;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    @(negedge clk);
  endtask

  // Reset the DUT and the memory model. Return at the falling edge after release (FSM in BOOT).
  task automatic reset_dut();
    rstn = 1'b0; fetch_en = 1'b1; imem_req_ready = 1'b1; pipe_stall = 1'b0;
    pipe_flush = 1'b0; flush_pc = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    hold = 1'b0; pend.delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; fetch_en = 1'b1; imem_req_ready = 1'b1; pipe_stall = 1'b0;
    pipe_flush = 1'b0; flush_pc = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    hold = 1'b0; pend.delete();
    @(negedge clk);
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    n_vec++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rst_req_addr: got %h want 00000000", imem_req_addr); end
    n_vec++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
    n_vec++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 00000000", instr); end
    n_vec++; if (instr_tag !== 32'h0) begin n_bad++; $display("FAIL rst_tag: got %h want 00000000", instr_tag); end
    @(negedge clk);
    rstn = 1'b1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL boot_req_valid: got %b want 0", imem_req_valid); end
    step();
    n_vec++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
    step(); step();
    // Reset asserted mid-flight drops everything.
    rstn = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; pend.delete();
    #1;
    n_vec++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_instr_valid: got %b want 0", instr_valid); end
    n_vec++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL midrst_addr: got %h want 00000000", imem_req_addr); end
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_req_valid: got %b want 0", imem_req_valid); end
  endtask

  // Scenario 1: streaming fetch, one word per cycle after a cycle of latency.
  task automatic test_stream();
    logic [31:0] e_addr;
    logic [31:0] e_tag;
    reset_dut();
    step();
    n_vec++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL s1_addr0: got %h want 00000000", imem_req_addr); end
    n_vec++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL s1_iv_c1: got %b want 0", instr_valid); end
    for (int k = 2; k <= 6; k++) begin
      step();
      e_addr = 32'(k - 1) << 2;
      e_tag  = 32'(k - 2) << 2;
      n_vec++; if (imem_req_addr !== e_addr) begin n_bad++; $display("FAIL s1_addr c%0d: got %h want %h", k, imem_req_addr, e_addr); end
      n_vec++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL s1_iv c%0d: got %b want 1", k, instr_valid); end
      n_vec++; if (instr_tag !== e_tag) begin n_bad++; $display("FAIL s1_tag c%0d: got %h want %h", k, instr_tag, e_tag); end
      n_vec++; if (instr !== (e_tag + 32'h1000_0000)) begin n_bad++; $display("FAIL s1_instr c%0d: got %h want %h", k, instr, e_tag + 32'h1000_0000); end
    end
  endtask

  // Scenario 2: stall with a full queue holds the head and blocks requests.
  task automatic test_stall_full();
    reset_dut();
    pipe_stall = 1'b1;
    step(); step(); step();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL s2_iv %0d: got %b want 1", i, instr_valid); end
      n_vec++; if (instr_tag !== 32'h0) begin n_bad++; $display("FAIL s2_tag %0d: got %h want 00000000", i, instr_tag); end
      n_vec++; if (instr !== 32'h1000_0000) begin n_bad++; $display("FAIL s2_instr %0d: got %h want 10000000", i, instr); end
      n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL s2_req_valid %0d: got %b want 0", i, imem_req_valid); end
      if (i < 2) step();
    end
    pipe_stall = 1'b0;
    step();
    n_vec++; if (instr_tag !== 32'h4) begin n_bad++; $display("FAIL s2_tag_after: got %h want 00000004", instr_tag); end
    n_vec++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL s2_req_resume: got %b want 1", imem_req_valid); end
    n_vec++; if (imem_req_addr !== 32'h8) begin n_bad++; $display("FAIL s2_addr_resume: got %h want 00000008", imem_req_addr); end
    step();
    n_vec++; if (instr_tag !== 32'h8) begin n_bad++; $display("FAIL s2_tag_next: got %h want 00000008", instr_tag); end
  endtask

  // Scenario 3: redirect with two requests in flight; both responses are discarded.
  task automatic test_flush_inflight();
    reset_dut();
    step(); step(); step(); step(); step();
    n_vec++; if (imem_req_addr !== 32'h10) begin n_bad++; $display("FAIL s3_addr10: got %h want 00000010", imem_req_addr); end
    hold = 1'b1;
    step();
    n_vec++; if (imem_req_addr !== 32'h14) begin n_bad++; $display("FAIL s3_addr14: got %h want 00000014", imem_req_addr); end
    n_vec++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL s3_iv_wait: got %b want 0", instr_valid); end
    step();
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL s3_full: got %b want 0", imem_req_valid); end
    pipe_flush = 1'b1; flush_pc = 32'h203;
    step();
    pipe_flush = 1'b0;
    n_vec++; if (imem_req_addr !== 32'h200) begin n_bad++; $display("FAIL s3_target: got %h want 00000200", imem_req_addr); end
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL s3_no_credit: got %b want 0", imem_req_valid); end
    hold = 1'b0;
    step();
    n_vec++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL s3_drop1: got %b want 0", instr_valid); end
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL s3_req_drop1: got %b want 0", imem_req_valid); end
    step();
    n_vec++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL s3_drop2: got %b want 0", instr_valid); end
    n_vec++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL s3_req_new: got %b want 1", imem_req_valid); end
    n_vec++; if (imem_req_addr !== 32'h200) begin n_bad++; $display("FAIL s3_addr_new: got %h want 00000200", imem_req_addr); end
    step();
    n_vec++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL s3_iv_new: got %b want 1", instr_valid); end
    n_vec++; if (instr_tag !== 32'h200) begin n_bad++; $display("FAIL s3_tag_new: got %h want 00000200", instr_tag); end
    n_vec++; if (instr !== 32'h1000_0200) begin n_bad++; $display("FAIL s3_instr_new: got %h want 10000200", instr); end
  endtask

  // Scenario 4: memory not ready for four cycles; the request holds its address.
  task automatic test_ready_low();
    reset_dut();
    step(); step(); step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL s4_valid %0d: got %b want 1", i, imem_req_valid); end
      n_vec++; if (imem_req_addr !== 32'h8) begin n_bad++; $display("FAIL s4_addr %0d: got %h want 00000008", i, imem_req_addr); end
      if (i < 3) step();
    end
    imem_req_ready = 1'b1;
    step();
    n_vec++; if (imem_req_addr !== 32'hC) begin n_bad++; $display("FAIL s4_addr_next: got %h want 0000000c", imem_req_addr); end
    n_vec++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL s4_iv: got %b want 1", instr_valid); end
    n_vec++; if (instr_tag !== 32'h8) begin n_bad++; $display("FAIL s4_tag: got %h want 00000008", instr_tag); end
  endtask

  // Scenario 5: flush, response and stall in the same cycle.
  task automatic test_flush_rsp_stall();
    reset_dut();
    step(); step();
    pipe_stall = 1'b1; pipe_flush = 1'b1; flush_pc = 32'h100;
    #1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL s5_masked: got %b want 0", imem_req_valid); end
    step();
    pipe_stall = 1'b0; pipe_flush = 1'b0;
    #1;
    n_vec++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL s5_req: got %b want 1", imem_req_valid); end
    n_vec++; if (imem_req_addr !== 32'h100) begin n_bad++; $display("FAIL s5_addr: got %h want 00000100", imem_req_addr); end
    n_vec++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL s5_iv_empty: got %b want 0", instr_valid); end
    step();
    n_vec++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL s5_iv: got %b want 1", instr_valid); end
    n_vec++; if (instr_tag !== 32'h100) begin n_bad++; $display("FAIL s5_tag: got %h want 00000100", instr_tag); end
    n_vec++; if (instr !== 32'h1000_0100) begin n_bad++; $display("FAIL s5_instr: got %h want 10000100", instr); end
  endtask

  // Scenario 6: halt with two requests in flight; drain them, then resume.
  task automatic test_halt_drain();
    reset_dut();
    hold = 1'b1;
    step(); step(); step();
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL s6_full: got %b want 0", imem_req_valid); end
    fetch_en = 1'b0; hold = 1'b0;
    step();
    n_vec++; if (instr_tag !== 32'h0 || instr_valid !== 1'b1) begin n_bad++; $display("FAIL s6_d0: got v=%b tag=%h want v=1 tag=00000000", instr_valid, instr_tag); end
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL s6_req_d0: got %b want 0", imem_req_valid); end
    step();
    n_vec++; if (instr_tag !== 32'h4 || instr_valid !== 1'b1) begin n_bad++; $display("FAIL s6_d1: got v=%b tag=%h want v=1 tag=00000004", instr_valid, instr_tag); end
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL s6_req_d1: got %b want 0", imem_req_valid); end
    step();
    n_vec++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL s6_empty: got %b want 0", instr_valid); end
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL s6_halt_req: got %b want 0", imem_req_valid); end
    step();
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL s6_halt_req2: got %b want 0", imem_req_valid); end
    fetch_en = 1'b1;
    step();
    n_vec++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL s6_resume: got %b want 1", imem_req_valid); end
    n_vec++; if (imem_req_addr !== 32'h8) begin n_bad++; $display("FAIL s6_resume_addr: got %h want 00000008", imem_req_addr); end
    step();
    n_vec++; if (instr_tag !== 32'h8) begin n_bad++; $display("FAIL s6_resume_tag: got %h want 00000008", instr_tag); end
  endtask

  // Redirect during BOOT with unaligned target near the top of memory; PC wraps to 0.
  task automatic test_flush_wrap();
    reset_dut();
    pipe_flush = 1'b1; flush_pc = 32'hFFFF_FFFF;
    #1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL w_boot_valid: got %b want 0", imem_req_valid); end
    step();
    pipe_flush = 1'b0;
    #1;
    n_vec++; if (imem_req_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL w_addr: got %h want fffffffc", imem_req_addr); end
    n_vec++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL w_valid: got %b want 1", imem_req_valid); end
    step();
    n_vec++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL w_wrap: got %h want 00000000", imem_req_addr); end
    n_vec++; if (instr_tag !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL w_tag: got %h want fffffffc", instr_tag); end
    n_vec++; if (instr !== 32'h0FFF_FFFC) begin n_bad++; $display("FAIL w_instr: got %h want 0ffffffc", instr); end
  endtask

  initial begin
    rstn = 1'b0; fetch_en = 1'b1; imem_req_ready = 1'b1; pipe_stall = 1'b0;
    pipe_flush = 1'b0; flush_pc = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    hold = 1'b0;
    test_reset();
    test_stream();
    test_stall_full();
    test_flush_inflight();
    test_ready_low();
    test_flush_rsp_stall();
    test_halt_drain();
    test_flush_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
